// File: rtl/iter_div_unit.sv
// Multi-cycle restoring radix-2 integer divider with valid/ready handshakes.
// Signed operands are divided as magnitudes; a final FIX cycle applies the
// result signs. Divide-by-zero skips the iteration and returns all-ones with
// the raw dividend as remainder.
module iter_div_unit #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic             dvs_zero;
  logic [WIDTH-1:0] abs_dvd;
  logic [WIDTH-1:0] abs_dvs;
  logic [CW-1:0]    n_bits;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign accept   = in_valid && (state == IDLE) && !flush;
  assign dvs_zero = (divisor == '0);

  // INT_MIN maps onto itself here, which is exactly the unsigned magnitude
  assign abs_dvd = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_dvs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Iteration count: significant bits of the dividend magnitude, or full width
  always_comb begin
    n_bits = CW'(1);
    if (EARLY_OUT != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (abs_dvd[i]) n_bits = CW'(i + 1);
      end
    end else begin
      n_bits = CW'(WIDTH);
    end
  end

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  // Sequencing: IDLE -> BUSY (N steps) -> FIX -> DONE, or IDLE -> DONE on divide-by-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dvs_zero) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              cnt   <= n_bits;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX:  state <= DONE;
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      rem_q  <= '0;
      dvd_q  <= abs_dvd << (CW'(WIDTH) - n_bits);
      dvs_q  <= abs_dvs;
      sign_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      sign_r <= is_signed && dividend[WIDTH-1];
      if (dvs_zero) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (!flush && state == BUSY) begin
      rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_q <= {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    end else if (!flush && state == FIX) begin
      quotient  <= sign_q ? -dvd_q : dvd_q;
      remainder <= sign_r ? -rem_q : rem_q;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: three instances (32-bit full-length,
// 32-bit early-out, 8-bit full-length) share one stimulus port, selected by
// 'sel'. Expected results are queued on accept and compared on out_valid.
module tb_iter_div_unit;

  typedef struct {
    int          sel;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        is_signed;
  logic        out_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  int          sel;

  logic        a_in_ready, a_out_valid, a_dbz, a_busy;
  logic [31:0] a_q, a_r;
  logic        b_in_ready, b_out_valid, b_dbz, b_busy;
  logic [31:0] b_q, b_r;
  logic        c_in_ready, c_out_valid, c_dbz, c_busy;
  logic [7:0]  c_q, c_r;

  logic        obs_in_ready, obs_out_valid, obs_dbz, obs_busy;
  logic [31:0] obs_q, obs_r;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t tbl[14];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  iter_div_unit #(.WIDTH(32), .EARLY_OUT(0)) dut_full (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid && sel == 0), .in_ready(a_in_ready),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .quotient(a_q), .remainder(a_r), .div_by_zero(a_dbz), .busy(a_busy)
  );

  iter_div_unit #(.WIDTH(32), .EARLY_OUT(1)) dut_early (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid && sel == 1), .in_ready(b_in_ready),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .quotient(b_q), .remainder(b_r), .div_by_zero(b_dbz), .busy(b_busy)
  );

  iter_div_unit #(.WIDTH(8), .EARLY_OUT(0)) dut_narrow (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid && sel == 2), .in_ready(c_in_ready),
    .is_signed(is_signed), .dividend(dividend[7:0]), .divisor(divisor[7:0]),
    .out_valid(c_out_valid), .out_ready(out_ready),
    .quotient(c_q), .remainder(c_r), .div_by_zero(c_dbz), .busy(c_busy)
  );

  // Route the selected instance onto one set of observation signals
  always_comb begin
    obs_in_ready  = a_in_ready;
    obs_out_valid = a_out_valid;
    obs_dbz       = a_dbz;
    obs_busy      = a_busy;
    obs_q         = a_q;
    obs_r         = a_r;
    if (sel == 1) begin
      obs_in_ready  = b_in_ready;
      obs_out_valid = b_out_valid;
      obs_dbz       = b_dbz;
      obs_busy      = b_busy;
      obs_q         = b_q;
      obs_r         = b_r;
    end else if (sel == 2) begin
      obs_in_ready  = c_in_ready;
      obs_out_valid = c_out_valid;
      obs_dbz       = c_dbz;
      obs_busy      = c_busy;
      obs_q         = {24'd0, c_q};
      obs_r         = {24'd0, c_r};
    end
  end

  // Hard stop in case something deadlocks outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at a negedge where out_valid is high and out_ready is set
  task automatic checkOutput(input string tag, input int lat);
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_scoreboard: got output required none pending", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_latency"}, 32'(lat), 32'(e.lat));
    cmp({tag, "_quotient"}, obs_q, e.q);
    cmp({tag, "_remainder"}, obs_r, e.r);
    cmp({tag, "_dbz"}, {31'd0, obs_dbz}, {31'd0, e.dbz});
  endtask

  task automatic applyStimulus(input string tag, input vec_t v);
    int   lat;
    logic seen;
    @(negedge clk);
    sel = v.sel;
    #1;
    cmp({tag, "_in_ready"}, {31'd0, obs_in_ready}, 32'd1);
    is_signed = v.sg;
    dividend  = v.a;
    divisor   = v.b;
    in_valid  = 1'b1;
    out_ready = (v.hold == 0);
    sb.push_back(v);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = ~v.a;
    divisor   = 32'd3;
    is_signed = ~v.sg;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (obs_out_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_timeout: got no out_valid in %0d cycles required %0d", tag, lat, v.lat);
      void'(sb.pop_back());
      return;
    end
    if (v.hold > 0) begin
      for (int k = 0; k < v.hold; k++) begin
        @(negedge clk);
        cmp({tag, "_hold_valid"}, {31'd0, obs_out_valid}, 32'd1);
        cmp({tag, "_hold_quotient"}, obs_q, v.q);
        cmp({tag, "_hold_remainder"}, obs_r, v.r);
      end
      out_ready = 1'b1;
    end
    checkOutput(tag, lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    sel       = 0;

    tbl[0]  = '{0, 1'b0, 32'd100,        32'd7,        32'd14,         32'd2,          1'b0, 34, 0};
    tbl[1]  = '{0, 1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34, 0};
    tbl[2]  = '{0, 1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,   32'd1,          1'b0, 34, 0};
    tbl[3]  = '{1, 1'b0, 32'd5,          32'd3,        32'd1,          32'd2,          1'b0, 5,  0};
    tbl[4]  = '{1, 1'b0, 32'd0,          32'd5,        32'd0,          32'd0,          1'b0, 3,  0};
    tbl[5]  = '{0, 1'b0, 32'h1234,       32'd0,        32'hFFFFFFFF,   32'h1234,       1'b1, 1,  0};
    tbl[6]  = '{0, 1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   32'd0,          1'b0, 34, 0};
    tbl[7]  = '{2, 1'b1, 32'h80,         32'd3,        32'h000000D6,   32'h000000FE,   1'b0, 10, 0};
    tbl[8]  = '{1, 1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 9,  0};
    tbl[9]  = '{1, 1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,   32'd0,          1'b0, 34, 0};
    tbl[10] = '{0, 1'b0, 32'd1000,       32'd33,       32'd30,         32'd10,         1'b0, 34, 10};
    tbl[11] = '{2, 1'b0, 32'hC8,         32'd7,        32'd28,         32'd4,          1'b0, 10, 0};
    tbl[12] = '{1, 1'b1, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,   32'hFFFFFFFB,   1'b1, 1,  0};
    tbl[13] = '{1, 1'b0, 32'h10,         32'h10,       32'd1,          32'd0,          1'b0, 7,  0};

    #1;
    cmp("reset_in_ready",  {31'd0, obs_in_ready},  32'd1);
    cmp("reset_out_valid", {31'd0, obs_out_valid}, 32'd0);
    cmp("reset_busy",      {31'd0, obs_busy},      32'd0);
    cmp("reset_dbz",       {31'd0, obs_dbz},       32'd0);
    cmp("reset_quotient",  obs_q, 32'd0);
    cmp("reset_remainder", obs_r, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), tbl[i]);
    end

    // Flush in the middle of an iteration, then a fresh divide
    @(negedge clk);
    sel = 0; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    cmp("flush_busy_before", {31'd0, obs_busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    cmp("flush_busy_after",  {31'd0, obs_busy},      32'd0);
    cmp("flush_out_valid",   {31'd0, obs_out_valid}, 32'd0);
    cmp("flush_in_ready",    {31'd0, obs_in_ready},  32'd1);
    applyStimulus("after_flush", '{0, 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 34, 0});

    // Flush coinciding with in_valid must not accept
    @(negedge clk);
    sel = 1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    cmp("flush_accept_busy",      {31'd0, obs_busy},      32'd0);
    cmp("flush_accept_out_valid", {31'd0, obs_out_valid}, 32'd0);

    // Asynchronous reset in the middle of an iteration
    @(negedge clk);
    sel = 0; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("midrst_busy",      {31'd0, obs_busy},      32'd0);
    cmp("midrst_in_ready",  {31'd0, obs_in_ready},  32'd1);
    cmp("midrst_out_valid", {31'd0, obs_out_valid}, 32'd0);
    cmp("midrst_dbz",       {31'd0, obs_dbz},       32'd0);
    cmp("midrst_quotient",  obs_q, 32'd0);
    cmp("midrst_remainder", obs_r, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after_reset", '{2, 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 10, 0});

    cmp("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
